// File: rtl/mem_access_stage.sv
// MEM pipeline stage: issues one req/ack data-memory access per load/store, steers byte lanes,
// extends load data and registers the result into the MEM/WB boundary.
package mem_access_pkg;
  typedef struct packed {
    logic       reg_write;
    logic       mem_to_reg;
    logic [4:0] rd;
    logic       mem_read;
    logic       mem_write;
    logic [2:0] funct3;
  } control_type;
endpackage

module mem_access_stage
  import mem_access_pkg::*;
#(
  parameter int MAX_WAIT = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        valid_in,
  input  control_type control_in,
  input  logic [31:0] alu_data_in,
  input  logic [31:0] memory_data_in,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        stall,
  output logic        valid_out,
  output control_type control_out,
  output logic [31:0] alu_data_out,
  output logic [31:0] mem_data_out,
  output logic        misaligned,
  output logic        bus_timeout
);

  localparam int CW = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;

  typedef enum logic {IDLE, WAIT} state_t;

  state_t      state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;

  logic        mem_op, is_byte, is_half, is_word, misal, issue, load;
  logic [3:0]  be_nxt;
  logic [31:0] wdata_nxt;
  control_type pend_ctrl;
  logic [31:0] pend_alu;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_val;

  logic        valid_nxt, mis_nxt, to_nxt;
  control_type ctrl_nxt;
  logic [31:0] alu_nxt, mdata_nxt;

  assign mem_op  = valid_in & (control_in.mem_read | control_in.mem_write);
  assign is_byte = (control_in.funct3[1:0] == 2'b00);
  assign is_half = (control_in.funct3[1:0] == 2'b01);
  assign is_word = !(is_byte | is_half);
  assign misal   = (is_half & alu_data_in[0]) | (is_word & (|alu_data_in[1:0]));
  assign issue   = mem_op & !misal;
  assign load    = (state == IDLE) & issue;
  assign dmem_req = (state == WAIT);

  always_comb begin
    be_nxt    = 4'b1111;
    wdata_nxt = memory_data_in;
    if (is_byte) begin
      be_nxt    = 4'b0001 << alu_data_in[1:0];
      wdata_nxt = {4{memory_data_in[7:0]}};
    end else if (is_half) begin
      be_nxt    = alu_data_in[1] ? 4'b1100 : 4'b0011;
      wdata_nxt = {2{memory_data_in[15:0]}};
    end
  end

  // Lane select uses the latched address; upstream inputs are not relied upon during WAIT.
  always_comb begin
    ld_byte = dmem_rdata[7:0];
    case (pend_alu[1:0])
      2'b01:   ld_byte = dmem_rdata[15:8];
      2'b10:   ld_byte = dmem_rdata[23:16];
      2'b11:   ld_byte = dmem_rdata[31:24];
      default: ld_byte = dmem_rdata[7:0];
    endcase
    ld_half = pend_alu[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (pend_ctrl.funct3)
      3'b000:  ld_val = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_val = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_val = {24'h0, ld_byte};
      3'b101:  ld_val = {16'h0, ld_half};
      default: ld_val = dmem_rdata;
    endcase
    if (!pend_ctrl.mem_read) ld_val = '0;
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    stall     = 1'b0;
    valid_nxt = 1'b0;
    ctrl_nxt  = '0;
    alu_nxt   = '0;
    mdata_nxt = '0;
    mis_nxt   = 1'b0;
    to_nxt    = 1'b0;
    case (state)
      IDLE: begin
        if (issue) begin
          stall     = 1'b1;
          state_nxt = WAIT;
          cnt_nxt   = '0;
        end else if (valid_in) begin
          valid_nxt = 1'b1;
          ctrl_nxt  = control_in;
          alu_nxt   = alu_data_in;
          mis_nxt   = mem_op;
        end
      end
      WAIT: begin
        stall = !dmem_ack;
        if (dmem_ack) begin
          state_nxt = IDLE;
          valid_nxt = 1'b1;
          ctrl_nxt  = pend_ctrl;
          alu_nxt   = pend_alu;
          mdata_nxt = ld_val;
        end else if (cnt == CW'(MAX_WAIT - 1)) begin
          state_nxt = IDLE;
          valid_nxt = 1'b1;
          ctrl_nxt  = pend_ctrl;
          alu_nxt   = pend_alu;
          to_nxt    = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      cnt          <= '0;
      dmem_we      <= 1'b0;
      dmem_addr    <= '0;
      dmem_be      <= '0;
      dmem_wdata   <= '0;
      pend_ctrl    <= '0;
      pend_alu     <= '0;
      valid_out    <= 1'b0;
      control_out  <= '0;
      alu_data_out <= '0;
      mem_data_out <= '0;
      misaligned   <= 1'b0;
      bus_timeout  <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      valid_out    <= valid_nxt;
      control_out  <= ctrl_nxt;
      alu_data_out <= alu_nxt;
      mem_data_out <= mdata_nxt;
      misaligned   <= mis_nxt;
      bus_timeout  <= to_nxt;
      if (load) begin
        dmem_we    <= control_in.mem_write;
        dmem_addr  <= {alu_data_in[31:2], 2'b00};
        dmem_be    <= be_nxt;
        dmem_wdata <= wdata_nxt;
        pend_ctrl  <= control_in;
        pend_alu   <= alu_data_in;
      end
    end
  end

endmodule
